// File: rtl/sram_responder.sv
// -----------------------------------------------------------------------------
// sram_responder
//   Device end of the 16-bit asynchronous-style SRAM bus. Stands in for the
//   external 256Kx16 SRAM so the MEM-stage controller can be exercised end to
//   end. After reset it clears its storage one word per cycle, then services
//   byte-lane writes and returns read data a fixed READ_LAT cycles after launch.
//   Protocol violations are recorded in sticky error flags.
//
//   Optional feature macro: SRAM_RESP_STATS_EN
//     defined   -> rd_count / wr_count count read launches / committed writes
//     undefined -> counter logic is not built, both outputs tie to 16'h0000
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous, active-low reset
//   sram_dq       bidirectional data bus (each byte lane driven or Z)
//   sram_address  word address, ADDR_W bits
//   SRAM_UB_N     upper byte lane enable, active-low
//   SRAM_LB_N     lower byte lane enable, active-low
//   SRAM_WE_N     write enable, active-low
//   SRAM_CE_N     chip enable, active-low
//   SRAM_OE_N     output enable, active-low
//   init_done     high once storage clearing has finished
//   err_flags     sticky: [0] WE/OE collision, [1] out-of-range address,
//                 [2] access attempted during clearing
//   rd_count      read launches (wraps)
//   wr_count      committed writes (wraps)
//   dbg_state     FSM state: 0 = INIT (clearing), 1 = IDLE (servicing)
//   dbg_dq_oe     per-lane drive enables of sram_dq: [1] upper, [0] lower
//
// Bus handshake: there is no valid/ready pair on this bus. Every rising edge
// samples the controls; a cycle is a transfer only while SRAM_CE_N is low.
// WE_N low commits a write that same edge; WE_N high with OE_N low launches a
// read whose data appears on sram_dq READ_LAT cycles later, provided the
// controller is still presenting a read (CE_N=0, OE_N=0, WE_N=1) at that time.
// READ_LAT must lie in 1..4; DEPTH_W must be smaller than ADDR_W.
// -----------------------------------------------------------------------------
module sram_responder #(
    parameter int ADDR_W   = 18,
    parameter int DEPTH_W  = 12,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [15:0]       sram_dq,
    input  logic [ADDR_W-1:0] sram_address,
    input  logic              SRAM_UB_N,
    input  logic              SRAM_LB_N,
    input  logic              SRAM_WE_N,
    input  logic              SRAM_CE_N,
    input  logic              SRAM_OE_N,
    output logic              init_done,
    output logic [2:0]        err_flags,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic              dbg_state,
    output logic [1:0]        dbg_dq_oe
);

    localparam int                 DEPTH    = 1 << DEPTH_W;
    localparam logic [DEPTH_W-1:0] PTR_LAST = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [DEPTH_W-1:0]   r_ptr;
    logic                 w_clear;
    logic [15:0]          r_mem [DEPTH];
    logic [2:0]           r_err;

    // Bus decode (only meaningful once clearing has finished)
    logic                 w_active;
    logic                 w_in_range;
    logic [DEPTH_W-1:0]   w_word_addr;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_collide;
    logic [15:0]          w_rd_data;
    logic                 w_bus_rd;
    logic                 w_oe_ub;
    logic                 w_oe_lb;

    // Read pipeline: stage READ_LAT-1 is the one presented on the bus
    logic                 r_pv [READ_LAT];
    logic [15:0]          r_pd [READ_LAT];
    logic [1:0]           r_pl [READ_LAT];
    logic                 w_sv [READ_LAT];
    logic [15:0]          w_sd [READ_LAT];
    logic [1:0]           w_sl [READ_LAT];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: if (r_ptr == PTR_LAST) w_state_next = ST_IDLE;
            ST_IDLE: w_state_next = ST_IDLE;
            default: w_state_next = ST_INIT;
        endcase
    end

    always_comb begin
        init_done = (r_state == ST_IDLE);
        w_clear   = (r_state == ST_INIT);
        dbg_state = (r_state == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_clear) begin
            r_ptr <= r_ptr + DEPTH_W'(1);
        end
    end

    // ---------------------------------------------------------------- decode
    assign w_active    = (r_state == ST_IDLE) && !SRAM_CE_N;
    assign w_in_range  = (sram_address[ADDR_W-1:DEPTH_W] == '0);
    assign w_word_addr = sram_address[DEPTH_W-1:0];
    assign w_wr        = w_active && !SRAM_WE_N;
    assign w_rd        = w_active && SRAM_WE_N && !SRAM_OE_N;
    assign w_collide   = w_wr && !SRAM_OE_N;
    assign w_rd_data   = w_in_range ? r_mem[w_word_addr] : 16'h0000;

    // ---------------------------------------------------------------- storage
    // No reset on the array: the INIT state clears it word by word.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_mem[r_ptr] <= 16'h0000;
        end else if (w_wr && w_in_range) begin
            if (!SRAM_UB_N) r_mem[w_word_addr][15:8] <= sram_dq[15:8];
            if (!SRAM_LB_N) r_mem[w_word_addr][7:0]  <= sram_dq[7:0];
        end
    end

    // ---------------------------------------------------------------- errors
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= '0;
        end else begin
            if (w_collide)                          r_err[0] <= 1'b1;
            if ((w_wr || w_rd) && !w_in_range)      r_err[1] <= 1'b1;
            if (w_clear && !SRAM_CE_N)              r_err[2] <= 1'b1;
        end
    end

    assign err_flags = r_err;

    // ---------------------------------------------------------------- read pipe
    // w_s*[i] is what stage i would load; entry 0 is the launch itself.
    always_comb begin
        w_sv[0] = w_rd;
        w_sd[0] = w_rd_data;
        w_sl[0] = {~SRAM_UB_N, ~SRAM_LB_N};
        for (int i = 1; i < READ_LAT; i++) begin
            w_sv[i] = r_pv[i-1];
            w_sd[i] = r_pd[i-1];
            w_sl[i] = r_pl[i-1];
        end
    end

    // Inner stages shift every cycle (bubbles included). The final stage only
    // takes a valid entry, so the last delivered word stays put until the
    // next launch arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= 16'h0000;
                r_pl[i] <= 2'b00;
            end
        end else begin
            for (int i = 0; i < READ_LAT - 1; i++) begin
                r_pv[i] <= w_sv[i];
                r_pd[i] <= w_sd[i];
                r_pl[i] <= w_sl[i];
            end
            if (w_sv[READ_LAT-1]) begin
                r_pv[READ_LAT-1] <= 1'b1;
                r_pd[READ_LAT-1] <= w_sd[READ_LAT-1];
                r_pl[READ_LAT-1] <= w_sl[READ_LAT-1];
            end
        end
    end

    // ---------------------------------------------------------------- bus drive
    // A collision has WE_N low, so w_bus_rd keeps the bus released then.
    assign w_bus_rd = !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
    assign w_oe_ub  = w_bus_rd && r_pv[READ_LAT-1] && r_pl[READ_LAT-1][1];
    assign w_oe_lb  = w_bus_rd && r_pv[READ_LAT-1] && r_pl[READ_LAT-1][0];

    assign sram_dq[15:8] = w_oe_ub ? r_pd[READ_LAT-1][15:8] : 8'hzz;
    assign sram_dq[7:0]  = w_oe_lb ? r_pd[READ_LAT-1][7:0]  : 8'hzz;
    assign dbg_dq_oe     = {w_oe_ub, w_oe_lb};

    // ---------------------------------------------------------------- stats
`ifdef SRAM_RESP_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_count <= 16'h0000;
            r_wr_count <= 16'h0000;
        end else begin
            if (w_rd) r_rd_count <= r_rd_count + 16'd1;
            if (w_wr) r_wr_count <= r_wr_count + 16'd1;
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`else
    assign rd_count = 16'h0000;
    assign wr_count = 16'h0000;
`endif

endmodule
